// File: rtl/bitfusion_pkg.sv
// Shared types and helpers for the bitfusion column-bottom datapath.
package bitfusion_pkg;

  localparam int unsigned PSUM_W_DEFAULT = 32;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} acc_state_t;

  // Signed add with one guard bit; clamps to the signed PSUM range on overflow.
  function automatic logic [PSUM_W_DEFAULT-1:0] sat_add(
    input  logic [PSUM_W_DEFAULT-1:0] a,
    input  logic [PSUM_W_DEFAULT-1:0] b,
    output logic                      sat_out
  );
    logic [PSUM_W_DEFAULT:0] s;
    s = {a[PSUM_W_DEFAULT-1], a} + {b[PSUM_W_DEFAULT-1], b};
    sat_out = s[PSUM_W_DEFAULT] ^ s[PSUM_W_DEFAULT-1];
    if (sat_out) begin
      sat_add = s[PSUM_W_DEFAULT] ? {1'b1, {(PSUM_W_DEFAULT-1){1'b0}}}
                                  : {1'b0, {(PSUM_W_DEFAULT-1){1'b1}}};
    end else begin
      sat_add = s[PSUM_W_DEFAULT-1:0];
    end
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with first-word-fall-through head and registered flags.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_next;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_comb begin
    count_next = count;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count_next;
      full  <= (count_next == CW'(DEPTH));
      empty <= (count_next == CW'(0));
    end
  end

endmodule

// File: rtl/psum_accumulator.sv
// Column-bottom psum accumulator: sums beats per output, saturates, optional ReLU, FIFOs results.
module psum_accumulator
  import bitfusion_pkg::*;
#(
  parameter int unsigned PSUM_W     = PSUM_W_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_passes,
  input  logic [CNT_W-1:0]  num_outputs,
  input  logic              relu_en,
  input  logic [PSUM_W-1:0] psum_in,
  input  logic              psum_valid,
  output logic              in_ready,
  output logic [PSUM_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              sat_flag
);

  acc_state_t        state;
  logic [PSUM_W-1:0] acc;
  logic [CNT_W-1:0]  pass_cnt;
  logic [CNT_W-1:0]  out_cnt;
  logic [CNT_W-1:0]  passes_q;
  logic [CNT_W-1:0]  outputs_q;
  logic              relu_q;

  logic [PSUM_W-1:0] sum;
  logic              sum_sat;
  logic              last_pass;
  logic              beat;
  logic              push;
  logic [PSUM_W-1:0] push_data;
  logic              fifo_full;
  logic              fifo_empty;

  // Full flag is registered, so a beat is only accepted when a FIFO slot is guaranteed.
  always_comb begin
    sum_sat   = 1'b0;
    sum       = sat_add(acc, psum_in, sum_sat);
    last_pass = (pass_cnt == passes_q - CNT_W'(1));
    beat      = (state == ACCUM) && psum_valid && !fifo_full;
    push      = beat && last_pass;
    push_data = (relu_q && sum[PSUM_W-1]) ? '0 : sum;
  end

  assign in_ready  = (state == ACCUM) && !fifo_full;
  assign busy      = (state != IDLE);
  assign out_valid = !fifo_empty;

  always_ff @(posedge clk) begin
    if (RST) begin
      state     <= IDLE;
      acc       <= '0;
      pass_cnt  <= '0;
      out_cnt   <= '0;
      passes_q  <= '0;
      outputs_q <= '0;
      relu_q    <= 1'b0;
      done      <= 1'b0;
      sat_flag  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            passes_q  <= (num_passes == '0) ? CNT_W'(1) : num_passes;
            outputs_q <= num_outputs;
            relu_q    <= relu_en;
            acc       <= '0;
            pass_cnt  <= '0;
            out_cnt   <= '0;
            sat_flag  <= 1'b0;
            state     <= (num_outputs == '0) ? DRAIN : ACCUM;
          end
        end
        ACCUM: begin
          if (beat) begin
            if (sum_sat) sat_flag <= 1'b1;
            if (last_pass) begin
              acc      <= '0;
              pass_cnt <= '0;
              out_cnt  <= out_cnt + CNT_W'(1);
              if (out_cnt == outputs_q - CNT_W'(1)) state <= DRAIN;
            end else begin
              acc      <= sum;
              pass_cnt <= pass_cnt + CNT_W'(1);
            end
          end
        end
        DRAIN: begin
          if (fifo_empty) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (PSUM_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (RST),
    .push      (push),
    .push_data (push_data),
    .pop       (out_ready),
    .pop_data  (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed scoreboard bench for psum_accumulator.
module tb_psum_accumulator;

  localparam int unsigned PSUM_W = 32;
  localparam int unsigned CNT_W  = 16;

  logic              clk = 1'b0;
  logic              RST;
  logic              start;
  logic [CNT_W-1:0]  num_passes;
  logic [CNT_W-1:0]  num_outputs;
  logic              relu_en;
  logic [PSUM_W-1:0] psum_in;
  logic              psum_valid;
  logic              in_ready;
  logic [PSUM_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;
  logic              sat_flag;

  psum_accumulator dut (
    .clk         (clk),
    .RST         (RST),
    .start       (start),
    .num_passes  (num_passes),
    .num_outputs (num_outputs),
    .relu_en     (relu_en),
    .psum_in     (psum_in),
    .psum_valid  (psum_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .done        (done),
    .sat_flag    (sat_flag)
  );

  always #5 clk = ~clk;

  int                vectors     = 0;
  int                miscompares = 0;
  logic [PSUM_W-1:0] exp_q[$];
  logic              accepted;
  logic              done_s;
  logic              busy_s;
  int                acc_cnt;
  logic [PSUM_W-1:0] v;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sample at negedge (handshakes + scoreboard), then advance past the next posedge.
  task automatic cycle();
    @(negedge clk);
    accepted = psum_valid && in_ready;
    done_s   = done;
    busy_s   = busy;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL out_extra: observed %0h expected no output", out_data);
      end else begin
        chk("out_data", 64'(out_data), 64'(exp_q.pop_front()));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [PSUM_W-1:0] val);
    int n;
    psum_in    = val;
    psum_valid = 1'b1;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!accepted && n < 20);
    chk("beat_accept", 64'(accepted), 64'(1));
    psum_valid = 1'b0;
  endtask

  task automatic run_job(input int passes, input int outputs, input logic relu);
    num_passes  = CNT_W'(passes);
    num_outputs = CNT_W'(outputs);
    relu_en     = relu;
    start       = 1'b1;
    cycle();
    start       = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int n = 0; n < budget; n++) begin
      cycle();
      if (done_s) break;
    end
    chk({tag, "_done"}, 64'(done_s), 64'(1));
    chk({tag, "_busy_at_done"}, 64'(busy_s), 64'(0));
    chk({tag, "_queue_drained"}, 64'(exp_q.size()), 64'(0));
    cycle();
    chk({tag, "_done_pulse"}, 64'(done_s), 64'(0));
  endtask

  initial begin
    RST = 1'b1; start = 1'b0; num_passes = '0; num_outputs = '0; relu_en = 1'b0;
    psum_in = '0; psum_valid = 1'b0; out_ready = 1'b0;
    cycle();
    cycle();
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_sat", 64'(sat_flag), 64'(0));
    RST = 1'b0;
    cycle();

    // 3-pass accumulation, single output
    out_ready = 1'b1;
    exp_q.push_back(32'd13);
    run_job(3, 1, 1'b0);
    chk("t1_busy", 64'(busy), 64'(1));
    send(32'd5);
    send(32'hFFFF_FFFE);
    send(32'd10);
    chk("t1_latency_valid", 64'(out_valid), 64'(1));
    chk("t1_latency_data", 64'(out_data), 64'(13));
    wait_done("t1", 10);
    chk("t1_sat", 64'(sat_flag), 64'(0));

    // Positive and negative saturation
    exp_q.push_back(32'h7FFF_FFFF);
    exp_q.push_back(32'h8000_0000);
    run_job(2, 2, 1'b0);
    send(32'h7FFF_FFF0);
    send(32'h0000_0100);
    send(32'h8000_0000);
    send(32'hFFFF_FFFF);
    wait_done("t2", 10);
    chk("t2_sat", 64'(sat_flag), 64'(1));

    // ReLU, single pass
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd4);
    run_job(1, 2, 1'b1);
    chk("t3_sat_cleared", 64'(sat_flag), 64'(0));
    send(32'hFFFF_FFF9);
    send(32'd4);
    wait_done("t3", 10);
    chk("t3_sat", 64'(sat_flag), 64'(0));

    // ReLU on a clamped negative result still flags saturation
    exp_q.push_back(32'd0);
    run_job(2, 1, 1'b1);
    send(32'h8000_0000);
    send(32'hFFFF_FFFF);
    wait_done("t3b", 10);
    chk("t3b_sat", 64'(sat_flag), 64'(1));

    // Backpressure: FIFO fills, in_ready drops, then drains in order
    out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) exp_q.push_back(PSUM_W'(i));
    run_job(1, 6, 1'b0);
    acc_cnt = 0;
    v = 32'd1;
    psum_in = v;
    psum_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (accepted) begin
        acc_cnt++;
        v = v + 32'd1;
        psum_in = v;
      end
    end
    chk("t4_accepted_when_full", 64'(acc_cnt), 64'(4));
    chk("t4_in_ready_full", 64'(in_ready), 64'(0));
    chk("t4_out_valid_full", 64'(out_valid), 64'(1));
    chk("t4_busy_full", 64'(busy), 64'(1));
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (accepted) begin
        acc_cnt++;
        if (acc_cnt == 6) begin
          psum_valid = 1'b0;
          break;
        end
        v = v + 32'd1;
        psum_in = v;
      end
    end
    psum_valid = 1'b0;
    chk("t4_accepted_total", 64'(acc_cnt), 64'(6));
    wait_done("t4", 40);
    chk("t4_out_valid_end", 64'(out_valid), 64'(0));

    // num_passes=0 behaves as 1
    exp_q.push_back(32'd3);
    exp_q.push_back(32'd4);
    run_job(0, 2, 1'b0);
    send(32'd3);
    send(32'd4);
    wait_done("t5", 10);

    // num_outputs=0 finishes two cycles after start with no output
    run_job(1, 0, 1'b0);
    cycle();
    chk("t5b_done_early", 64'(done_s), 64'(0));
    chk("t5b_busy", 64'(busy_s), 64'(1));
    cycle();
    chk("t5b_done", 64'(done_s), 64'(1));
    chk("t5b_busy_at_done", 64'(busy_s), 64'(0));
    chk("t5b_no_output", 64'(out_valid), 64'(0));

    // Reset mid-job discards FIFO contents
    out_ready = 1'b0;
    run_job(1, 5, 1'b0);
    send(32'd11);
    send(32'd22);
    chk("t6_out_valid_pre", 64'(out_valid), 64'(1));
    chk("t6_busy_pre", 64'(busy), 64'(1));
    RST = 1'b1;
    cycle();
    RST = 1'b0;
    chk("t6_out_valid", 64'(out_valid), 64'(0));
    chk("t6_busy", 64'(busy), 64'(0));
    chk("t6_in_ready", 64'(in_ready), 64'(0));
    chk("t6_out_data", 64'(out_data), 64'(0));
    out_ready = 1'b1;
    exp_q.push_back(32'd42);
    run_job(1, 1, 1'b0);
    send(32'd42);
    wait_done("t6", 10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/psum_accumulator.md
Name: psum_accumulator

Overview:
- Column-bottom stage directly downstream of the fusion-unit column: consumes the signed 32-bit psum leaving the last fusion unit.
- Accumulates a programmed number of partial-sum beats per output element, applying saturation and optional ReLU.
- Buffers finished results in a small output FIFO with a valid/ready handshake toward the output SRAM writer.
- Stalls the column through in_ready when the FIFO is full.

Parameters:
- PSUM_W, 32, width of psum input, accumulator and output data.
- FIFO_DEPTH, 4, output FIFO entries; power of two, at least 2.
- CNT_W, 16, width of the pass and output counters.

Ports:
- clk  in  1  clock
- RST  in  1  reset; one clock; reset is synchronous and active-high
- start  in  1  one-cycle pulse; latches config and begins a job (IDLE only)
- num_passes  in  CNT_W  psum beats summed per output; 0 treated as 1
- num_outputs  in  CNT_W  outputs per job; 0 means the job completes immediately
- relu_en  in  1  clamp negative results to 0 before FIFO write
- psum_in  in  PSUM_W  signed psum from fusion column
- psum_valid  in  1  psum_in valid this cycle
- in_ready  out  1  beat accepted when psum_valid && in_ready
- out_data  out  PSUM_W  FIFO head, first-word-fall-through
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  pop when out_valid && out_ready
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at job end
- sat_flag  out  1  sticky; set if any accumulation saturated during the job

Behaviour:
- Reset (synchronous, RST=1 at posedge) values: state=IDLE, acc=0, pass_cnt=0, out_cnt=0, FIFO emptied. Outputs: in_ready=0, out_valid=0, out_data=0, busy=0, done=0, sat_flag=0. RST mid-job aborts the job and discards FIFO contents.
- FSM has three states:
  - IDLE: on start, latch num_passes (0 becomes 1), num_outputs and relu_en; clear acc, counters and sat_flag; go to ACCUM. If num_outputs==0, go to DRAIN instead.
  - ACCUM: in_ready = !fifo_full, using the registered full flag. On each accepted beat:
    - sum = acc + psum_in computed in PSUM_W+1 bits, then clamped to [-2^(PSUM_W-1), 2^(PSUM_W-1)-1]; sat_flag set if clamped.
    - If pass_cnt==num_passes-1: push relu(sum) to the FIFO at this edge, acc<=0, pass_cnt<=0, out_cnt++. If this was output num_outputs-1, go to DRAIN.
    - Otherwise: acc<=sum, pass_cnt++.
  - DRAIN: in_ready=0. When the FIFO is empty, pulse done for one cycle and go to IDLE.
- start outside IDLE is ignored.
- Latency: final beat accepted at edge N, so out_valid=1 and out_data holds the result after edge N (1 cycle).
- FIFO rules:
  - Push and pop in the same cycle are both honoured; occupancy is unchanged.
  - A full FIFO deasserts in_ready one cycle later; no push is lost, because full is checked before acceptance.
  - Pop on empty is a no-op.
  - Pointers wrap modulo FIFO_DEPTH.
- psum_valid while in_ready=0: beat not consumed; upstream holds it.
- relu_en=1 and a clamped negative result: output 0, sat_flag still set.
- done and busy: done is asserted in the cycle state returns to IDLE; busy is 0 in that cycle.

Decomposition:
- bitfusion_pkg holds:
  - PSUM_W default constant.
  - typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} acc_state_t.
  - Saturating-add function sat_add(a,b,sat_out).
- Sub-module sync_fifo (parameters WIDTH, DEPTH): registered storage, first-word-fall-through head, full/empty flags, simultaneous push and pop.

Test Plan:
- num_passes=3, num_outputs=1, beats 5,-2,10, out_ready=1 -> one out_data=13 one cycle after third beat; done pulse; sat_flag=0.
- num_passes=2, beats 0x7FFFFFF0,0x00000100 -> out_data=0x7FFFFFFF, sat_flag=1; beats 0x80000000,-1 -> 0x80000000.
- relu_en=1, num_passes=1, beats -7,4 -> outputs 0 then 4.
- num_passes=1, num_outputs=6, FIFO_DEPTH=4, out_ready=0, psum_valid held 1 -> in_ready drops after 4 pushes. Raise out_ready -> all 6 values in order; done only after FIFO empties.
- num_passes=0 and num_outputs=0 cases -> passes treated as 1; num_outputs=0 gives done 2 cycles after start, with no output.
- RST=1 mid-ACCUM with 2 FIFO entries -> next cycle out_valid=0, busy=0, in_ready=0; new start behaves normally.
